uart_rx_param: RTL

- Parametrised next-generation UART receiver for the FPGA RISC-V platform: configurable data width, parity, stop bits and oversampling ratio.
- Adds ready/valid output holding, parity/framing error reporting and overrun detection.
- Sits between the board RX pin and the loader/MMIO UART register block; its consumer may stall.

---
 rtl/uart_rx_param.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver with ready/valid holding, parity/framing errors and sticky overrun.
// Define RX_MAJORITY_VOTE_EN to take each bit as the 2-of-3 vote around mid-bit (+1 cycle latency).
//
// state  | meaning
// IDLE   | line idle; waits for rx low once rx has been seen high
// START  | timing to mid start bit; sample 1 rejects a glitch
// DATA   | one sample per bit period, LSB first
// PARITY | one sample, compared against the expected parity
// STOP   | one sample per stop bit; a 0 flags a framing error
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 input_serial,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] output_byte,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif
    localparam logic [CNT_W-1:0] START_PT  = CNT_W'(MID + VOTE_DLY);
    localparam logic [CNT_W-1:0] BIT_PT    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY_MODE == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx, samp, armed;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 perr_f, perr_n, ferr_f, ferr_n, done, done_n;
    logic                 par_exp, hs, load, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= input_serial;
            rx      <= rx_meta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    // Decision is taken one cycle after mid so the three taps straddle it.
    logic rx_d1, rx_d2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx;
            rx_d2 <= rx_d1;
        end
    end
    assign samp = (rx_d2 & rx_d1) | (rx_d2 & rx) | (rx_d1 & rx);
`else
    assign samp = rx;
`endif

    // A held-low line (break) must go high before another start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             armed <= 1'b0;
        else if (state != IDLE) armed <= 1'b0;
        else if (rx)            armed <= 1'b1;
    end

    assign par_exp = (^shift) ^ ODD_PAR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr_f  <= 1'b0;
            ferr_f  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            perr_f  <= perr_n;
            ferr_f  <= ferr_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + CNT_W'(1);
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        perr_n    = perr_f;
        ferr_n    = ferr_f;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (!rx && armed) begin
                    state_n = START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end
            START: begin
                if (clk_cnt == START_PT) begin
                    clk_cnt_n = '0;
                    state_n   = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_PT) begin
                    clk_cnt_n = '0;
                    shift_n   = {samp, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (clk_cnt == BIT_PT) begin
                    clk_cnt_n = '0;
                    perr_n    = (samp != par_exp);
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_PT) begin
                    clk_cnt_n = '0;
                    if (!samp) ferr_n = 1'b1;
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign hs   = out_valid && out_ready;
    assign load = done && (!out_valid || out_ready);
    assign drop = done && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            output_byte   <= '0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (load) begin
                out_valid     <= 1'b1;
                output_byte   <= shift;
                parity_error  <= perr_f;
                framing_error <= ferr_f;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (drop)    overrun <= 1'b1;
            else if (hs) overrun <= 1'b0;
        end
    end

endmodule
